// File: rtl/tmu_burstwrite.sv
// Holds one assembled 256-bit burst and replays it as a 4-beat FML write.
// The request rises 2 cycles after accept; upstream stalls while the holding register is full.
module tmu_burstwrite #(
  parameter int fml_depth = 26
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 pipe_stb_i,
  output logic                 pipe_ack_o,
  input  logic [fml_depth-6:0] burst_addr,
  input  logic [15:0]          burst_sel,
  input  logic [255:0]         burst_do,
  output logic                 busy,
  output logic [fml_depth-1:0] fml_adr,
  output logic                 fml_stb,
  output logic                 fml_we,
  input  logic                 fml_ack,
  output logic [7:0]           fml_sel,
  output logic [63:0]          fml_do
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    DATA    = 2'd2
  } state_t;

  state_t state, state_nx;

  logic                 hold_valid;
  logic [fml_depth-6:0] hold_addr;
  logic [15:0]          hold_sel;
  logic [255:0]         hold_do;

  logic [255:0] data_sr;
  logic [15:0]  mask_sr;
  logic [1:0]   cnt;

  logic accept;
  logic hold_clr;
  logic eng_load;
  logic beat_issue;

  // Each 16-bit word covers two bytes of the 64-bit beat.
  function automatic logic [7:0] expand(input logic [3:0] m);
    return {{2{m[3]}}, {2{m[2]}}, {2{m[1]}}, {2{m[0]}}};
  endfunction

  assign pipe_ack_o = ~hold_valid & sys_rst_n;
  assign accept     = pipe_stb_i & pipe_ack_o;
  assign busy       = hold_valid | (state != IDLE);
  assign fml_we     = 1'b1;
  assign beat_issue = ((state == REQUEST) && fml_ack) || ((state == DATA) && (cnt != 2'd3));

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    hold_clr = 1'b0;
    eng_load = 1'b0;
    unique case (state)
      IDLE: begin
        if (hold_valid) begin
          hold_clr = 1'b1;
          if (hold_sel != 16'd0) begin
            eng_load = 1'b1;
            state_nx = REQUEST;
          end
        end
      end
      REQUEST: begin
        if (fml_ack) state_nx = DATA;
      end
      DATA: begin
        if (cnt == 2'd3) begin
          state_nx = IDLE;
          if (hold_valid) begin
            hold_clr = 1'b1;
            if (hold_sel != 16'd0) begin
              eng_load = 1'b1;
              state_nx = REQUEST;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_sel   <= '0;
      hold_do    <= '0;
      data_sr    <= '0;
      mask_sr    <= '0;
      cnt        <= '0;
      fml_adr    <= '0;
      fml_stb    <= 1'b0;
      fml_sel    <= '0;
      fml_do     <= '0;
    end else begin
      // An accept in the same cycle as an engine load leaves the register full.
      if (accept) begin
        hold_valid <= 1'b1;
        hold_addr  <= burst_addr;
        hold_sel   <= burst_sel;
        hold_do    <= burst_do;
      end else if (hold_clr) begin
        hold_valid <= 1'b0;
      end

      fml_stb <= (state_nx == REQUEST);

      if (eng_load) begin
        fml_adr <= {hold_addr, 5'b0};
        data_sr <= hold_do;
        mask_sr <= hold_sel;
      end

      if (beat_issue) begin
        fml_do  <= data_sr[255:192];
        fml_sel <= expand(mask_sr[15:12]);
        data_sr <= data_sr << 64;
        mask_sr <= mask_sr << 4;
        cnt     <= (state == REQUEST) ? 2'd0 : cnt + 2'd1;
      end else begin
        fml_sel <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tmu_burstwrite.sv
// Randomised and directed bench for tmu_burstwrite against a burst-queue reference model.
module tb_tmu_burstwrite;

  logic         sys_clk;
  logic         sys_rst_n;
  logic         pipe_stb_i;
  logic         pipe_ack_o;
  logic [20:0]  burst_addr;
  logic [15:0]  burst_sel;
  logic [255:0] burst_do;
  logic         busy;
  logic [25:0]  fml_adr;
  logic         fml_stb;
  logic         fml_we;
  logic         fml_ack;
  logic [7:0]   fml_sel;
  logic [63:0]  fml_do;

  tmu_burstwrite #(.fml_depth(26)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .pipe_stb_i(pipe_stb_i), .pipe_ack_o(pipe_ack_o),
    .burst_addr(burst_addr), .burst_sel(burst_sel), .burst_do(burst_do),
    .busy(busy), .fml_adr(fml_adr), .fml_stb(fml_stb), .fml_we(fml_we),
    .fml_ack(fml_ack), .fml_sel(fml_sel), .fml_do(fml_do)
  );

  typedef struct packed {
    logic [20:0]  addr;
    logic [15:0]  sel;
    logic [255:0] data;
  } burst_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  burst_t exp_q[$];
  burst_t cur;
  int beat = -1;
  logic prev_stb = 1'b0;
  int completed = 0;
  int busy_cnt = 0;
  int acc_cyc[$];
  int stb_rise[$];
  int beat3_cyc[$];
  logic [25:0] obs_adr[$];
  logic [7:0]  obs_sel[$];
  logic [63:0] obs_do[$];

  int ack_delay = 0;
  bit ack_rand = 0;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Beat k carries words 4k..4k+3; each word enables two byte lanes, word 4k on the top lanes.
  function automatic logic [7:0] model_sel(input logic [15:0] s, input int k);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[j] = s[15 - (4 * k + (7 - j) / 2)];
    return r;
  endfunction

  function automatic logic [63:0] model_do(input logic [255:0] d, input int k);
    logic [255:0] t;
    t = d >> (64 * (3 - k));
    return t[63:0];
  endfunction

  // Compare process: every cycle, outputs are checked against the queue of accepted bursts.
  always @(negedge sys_clk) begin
    if (beat >= 0) begin
      check("beat_sel", 64'(fml_sel), 64'(model_sel(cur.sel, beat)));
      check("beat_do", fml_do, model_do(cur.data, beat));
      check("stb_in_beat", 64'(fml_stb), 64'd0);
      obs_sel.push_back(fml_sel);
      obs_do.push_back(fml_do);
      if (beat == 3) begin
        beat3_cyc.push_back(cyc);
        completed++;
        beat = -1;
      end else begin
        beat++;
      end
    end else begin
      check("sel_idle", 64'(fml_sel), 64'd0);
    end
    if (fml_stb) begin
      check("busy_active", 64'(busy), 64'd1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_stb: got adr %h expected no request", fml_adr);
      end else begin
        check("req_adr", 64'(fml_adr), 64'({exp_q[0].addr, 5'b0}));
      end
      if (!prev_stb) begin
        stb_rise.push_back(cyc);
        obs_adr.push_back(fml_adr);
      end
      if (fml_ack && exp_q.size() != 0) begin
        cur = exp_q.pop_front();
        beat = 0;
      end
    end
    if (busy) busy_cnt++;
    if (pipe_stb_i && pipe_ack_o) begin
      acc_cyc.push_back(cyc);
      if (burst_sel != 16'd0) exp_q.push_back('{burst_addr, burst_sel, burst_do});
    end
    if (!sys_rst_n) begin
      exp_q.delete();
      beat = -1;
    end
    prev_stb = fml_stb;
  end

  initial begin
    int wcnt;
    fml_ack = 1'b0;
    wcnt = 0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (fml_stb && !fml_ack) begin
        if (wcnt >= ack_delay) begin
          fml_ack = 1'b1;
          wcnt = 0;
          if (ack_rand) ack_delay = $urandom_range(0, 5);
        end else begin
          wcnt++;
        end
      end else begin
        fml_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  task automatic send(input logic [20:0] a, input logic [15:0] s, input logic [255:0] d);
    int n;
    n = 0;
    pipe_stb_i = 1'b1;
    burst_addr = a;
    burst_sel  = s;
    burst_do   = d;
    @(negedge sys_clk);
    while (!pipe_ack_o && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    check("send_timeout", 64'(n >= 300), 64'd0);
    @(posedge sys_clk);
    #1;
    pipe_stb_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge sys_clk);
    #1;
    while ((exp_q.size() != 0 || beat >= 0 || busy) && n < 2000) begin
      @(negedge sys_clk);
      #1;
      n++;
    end
    check("drain_timeout", 64'(n >= 2000), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_ack", 64'(pipe_ack_o), 64'd1);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_rec();
    acc_cyc.delete();
    stb_rise.delete();
    beat3_cyc.delete();
    obs_adr.delete();
    obs_sel.delete();
    obs_do.delete();
    completed = 0;
  endtask

  function automatic logic [255:0] rand_data();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32 * i +: 32] = $urandom;
    return d;
  endfunction

  function automatic int qi(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  initial begin
    logic [255:0] d;
    logic [20:0]  a[3];
    int nz;

    sys_rst_n  = 1'b0;
    pipe_stb_i = 1'b0;
    burst_addr = '0;
    burst_sel  = '0;
    burst_do   = '0;
    repeat (3) @(negedge sys_clk);
    check("rst_stb", 64'(fml_stb), 64'd0);
    check("rst_sel", 64'(fml_sel), 64'd0);
    check("rst_do", fml_do, 64'd0);
    check("rst_adr", 64'(fml_adr), 64'd0);
    check("rst_we", 64'(fml_we), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ack", 64'(pipe_ack_o), 64'd0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("post_rst_ack", 64'(pipe_ack_o), 64'd1);
    @(posedge sys_clk);
    #1;

    // Single full burst with literal expectations.
    clear_rec();
    ack_delay = 3;
    for (int w = 0; w < 16; w++) d[255 - 16 * w -: 16] = 16'(w);
    send(21'h12345, 16'hFFFF, d);
    drain();
    check("t1_adr", 64'(obs_adr.size() > 0 ? obs_adr[0] : 26'h0), 64'h2468A0);
    check("t1_do0", obs_do.size() > 0 ? obs_do[0] : 64'h0, 64'h0000000100020003);
    check("t1_do3", obs_do.size() > 3 ? obs_do[3] : 64'h0, 64'h000C000D000E000F);
    for (int k = 0; k < 4; k++)
      check("t1_sel", 64'(obs_sel.size() > k ? obs_sel[k] : 8'h0), 64'hFF);
    check("t1_latency", 64'(qi(stb_rise, 0) - qi(acc_cyc, 0)), 64'd2);

    // Partial mask.
    clear_rec();
    ack_delay = 1;
    send(21'h00abc, 16'h8001, rand_data());
    drain();
    check("t2_sel0", 64'(obs_sel.size() > 0 ? obs_sel[0] : 8'h0), 64'hC0);
    check("t2_sel1", 64'(obs_sel.size() > 1 ? obs_sel[1] : 8'hFF), 64'h00);
    check("t2_sel2", 64'(obs_sel.size() > 2 ? obs_sel[2] : 8'hFF), 64'h00);
    check("t2_sel3", 64'(obs_sel.size() > 3 ? obs_sel[3] : 8'h0), 64'h03);

    // Zero mask: dropped, busy for exactly one cycle.
    clear_rec();
    busy_cnt = 0;
    send(21'h00055, 16'h0000, rand_data());
    repeat (5) @(negedge sys_clk);
    check("t3_busy_cycles", 64'(busy_cnt), 64'd1);
    check("t3_no_stb", 64'(stb_rise.size()), 64'd0);
    check("t3_ack_back", 64'(pipe_ack_o), 64'd1);
    @(posedge sys_clk);
    #1;

    // Backpressure (slow ack) and load/accept overlap (fast ack).
    for (int pass = 0; pass < 2; pass++) begin
      clear_rec();
      ack_delay = (pass == 0) ? 10 : 0;
      for (int i = 0; i < 3; i++) a[i] = 21'($urandom);
      for (int i = 0; i < 3; i++) send(a[i], 16'($urandom_range(1, 65535)), rand_data());
      drain();
      check("bp_count", 64'(completed), 64'd3);
      for (int i = 0; i < 3; i++)
        check("bp_order", 64'(obs_adr.size() > i ? obs_adr[i] : 26'h0), 64'({a[i], 5'b0}));
      check("bp_stall", 64'(qi(acc_cyc, 2)), 64'(qi(beat3_cyc, 0) + 1));
      check("bp_b2b", 64'(qi(stb_rise, 1)), 64'(qi(beat3_cyc, 0) + 1));
    end

    // Reset during beat 1 with a burst held.
    clear_rec();
    ack_delay = 2;
    send(21'h00111, 16'hFFFF, rand_data());
    send(21'h00222, 16'hFFFF, rand_data());
    begin
      int n;
      n = 0;
      while (beat != 1 && n < 100) begin
        @(negedge sys_clk);
        #1;
        n++;
      end
      check("t5_wait_beat", 64'(n >= 100), 64'd0);
    end
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    #1;
    check("t5_ack_in_rst", 64'(pipe_ack_o), 64'd0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("t5_stb", 64'(fml_stb), 64'd0);
    check("t5_sel", 64'(fml_sel), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    @(posedge sys_clk);
    #1;
    completed = 0;
    send(21'h00333, 16'h0F0F, rand_data());
    drain();
    check("t5_after_count", 64'(completed), 64'd1);
    check("t5_after_adr", 64'(obs_adr.size() > 0 ? obs_adr[obs_adr.size() - 1] : 26'h0), 64'h6660);

    // Random traffic.
    clear_rec();
    ack_rand = 1;
    nz = 0;
    for (int i = 0; i < 40; i++) begin
      logic [15:0] s;
      s = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      if (s != 16'h0) nz++;
      send(21'($urandom), s, rand_data());
      repeat ($urandom_range(0, 3)) begin
        @(posedge sys_clk);
        #1;
      end
    end
    drain();
    check("rand_count", 64'(completed), 64'(nz));
    check("rand_accepts", 64'(acc_cyc.size()), 64'd40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
